// File: rtl/dt_sched_pkg.sv
// Shared types for the timestep scheduler: FSM state encoding and the
// "no limiting requester" index convention.
`ifndef DT_WIDTH
`define DT_WIDTH 16
`endif

package dt_sched_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_STOP = 2'd2
  } sched_state_e;

  // win_idx value reported when the cap or the stop clamp sets the step
  function automatic int win_none(input int n);
    return n;
  endfunction

endpackage

// File: rtl/dt_min_tree.sv
// Balanced minimum tree over N flattened requests; on equal values the
// lower requester index wins.
module dt_min_tree #(
  parameter int N        = 4,
  parameter int DT_WIDTH = 16
) (
  input  logic [N*DT_WIDTH-1:0] req,
  output logic [DT_WIDTH-1:0]   min_val,
  output logic [$clog2(N):0]    min_idx
);

  localparam int IW = $clog2(N) + 1;
  localparam int P  = 2 ** $clog2(N);

  // heap layout: node k has children 2k+1 / 2k+2, leaves at P-1 .. 2P-2
  logic [DT_WIDTH-1:0] val [2*P-1];
  logic [IW-1:0]       idx [2*P-1];

  always_comb begin
    for (int k = 0; k < 2*P-1; k++) begin
      val[k] = '1;
      idx[k] = IW'(N);
    end
    for (int i = 0; i < N; i++) begin
      val[P-1+i] = req[i*DT_WIDTH +: DT_WIDTH];
      idx[P-1+i] = IW'(i);
    end
    // padding leaves sit to the right, so <= keeps real requesters ahead
    for (int k = P-2; k >= 0; k--) begin
      if (val[2*k+1] <= val[2*k+2]) begin
        val[k] = val[2*k+1];
        idx[k] = idx[2*k+1];
      end else begin
        val[k] = val[2*k+2];
        idx[k] = idx[2*k+2];
      end
    end
  end

  assign min_val = val[0];
  assign min_idx = idx[0];

endmodule

// File: rtl/dt_scheduler.sv
// Grants a common emulator timestep (minimum request, capped), accumulates
// emulated time and sequences run / hold / stop-at-time.
`ifndef DT_WIDTH
`define DT_WIDTH 16
`endif

module dt_scheduler
  import dt_sched_pkg::*;
#(
  parameter int                       N          = 4,
  parameter int                       DT_WIDTH   = `DT_WIDTH,
  parameter int                       TIME_WIDTH = 40,
  parameter logic [DT_WIDTH-1:0]      DT_MAX     = {DT_WIDTH{1'b1}}
) (
  input  logic                    emu_clk,
  input  logic                    emu_rst,
  input  logic [N*DT_WIDTH-1:0]   dt_req,
  input  logic                    stall_req,
  input  logic                    stop_en,
  input  logic [TIME_WIDTH-1:0]   t_stop,
  output logic [DT_WIDTH-1:0]     emu_dt,
  output logic [TIME_WIDTH-1:0]   emu_time,
  output logic [$clog2(N):0]      win_idx,
  output logic [1:0]              state,
  output logic [31:0]             step_cnt
);

  localparam int            IW       = $clog2(N) + 1;
  localparam logic [IW-1:0] WIN_NONE = IW'(win_none(N));

  sched_state_e        state_q, state_nxt;
  logic [DT_WIDTH-1:0] tree_min, dt_min, dt_clamp;
  logic [IW-1:0]       tree_idx, min_idx;
  logic [TIME_WIDTH:0] reach;
  logic                stop_hit;

  dt_min_tree #(.N(N), .DT_WIDTH(DT_WIDTH)) u_min_tree (
    .req     (dt_req),
    .min_val (tree_min),
    .min_idx (tree_idx)
  );

  always_comb begin
    dt_min  = tree_min;
    min_idx = tree_idx;
    if (tree_min > DT_MAX) begin
      dt_min  = DT_MAX;
      min_idx = WIN_NONE;
    end
  end

  // one extra bit so the stop compare never wraps
  assign reach    = {1'b0, emu_time} + (TIME_WIDTH+1)'(dt_min);
  assign stop_hit = stop_en && (reach >= {1'b0, t_stop});
  assign dt_clamp = (emu_time >= t_stop) ? '0 : DT_WIDTH'(t_stop - emu_time);

  always_comb begin
    state_nxt = state_q;
    emu_dt    = '0;
    win_idx   = WIN_NONE;
    if (!emu_rst) begin
      unique case (state_q)
        ST_RUN: begin
          if (stall_req) begin
            state_nxt = ST_HOLD;
          end else if (stop_hit) begin
            emu_dt    = dt_clamp;
            state_nxt = ST_STOP;
          end else begin
            emu_dt  = dt_min;
            win_idx = min_idx;
          end
        end
        ST_HOLD: begin
          if (!stall_req) state_nxt = ST_RUN;
        end
        ST_STOP: begin
          if (stall_req)                            state_nxt = ST_HOLD;
          else if (!stop_en || (t_stop > emu_time)) state_nxt = ST_RUN;
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      state_q  <= ST_RUN;
      emu_time <= '0;
      step_cnt <= '0;
    end else begin
      state_q  <= state_nxt;
      emu_time <= emu_time + TIME_WIDTH'(emu_dt);
      if ((emu_dt != '0) && (step_cnt != '1)) step_cnt <= step_cnt + 32'd1;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_dt_scheduler.sv
// Directed bench for dt_scheduler: main instance (N=4, cap 1000) plus a
// narrow-time instance for the wrap case.
module tb_dt_scheduler;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int TW = 40;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] dt_req;
  logic            stall_req;
  logic            stop_en;
  logic [TW-1:0]   t_stop;
  logic [DW-1:0]   emu_dt;
  logic [TW-1:0]   emu_time;
  logic [2:0]      win_idx;
  logic [1:0]      state;
  logic [31:0]     step_cnt;

  logic            rst_w;
  logic [7:0]      req_w;
  logic            zero_w;
  logic [7:0]      t_stop_w;
  logic [3:0]      w_dt;
  logic [7:0]      w_time;
  logic [1:0]      w_win;
  logic [1:0]      w_state;
  logic [31:0]     w_cnt;

  typedef struct {
    string       tag;
    logic [63:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  dt_scheduler #(.N(N), .DT_WIDTH(DW), .TIME_WIDTH(TW), .DT_MAX(16'd1000)) dut (
    .emu_clk   (clk),
    .emu_rst   (rst),
    .dt_req    (dt_req),
    .stall_req (stall_req),
    .stop_en   (stop_en),
    .t_stop    (t_stop),
    .emu_dt    (emu_dt),
    .emu_time  (emu_time),
    .win_idx   (win_idx),
    .state     (state),
    .step_cnt  (step_cnt)
  );

  dt_scheduler #(.N(2), .DT_WIDTH(4), .TIME_WIDTH(8)) dut_w (
    .emu_clk   (clk),
    .emu_rst   (rst_w),
    .dt_req    (req_w),
    .stall_req (zero_w),
    .stop_en   (zero_w),
    .t_stop    (t_stop_w),
    .emu_dt    (w_dt),
    .emu_time  (w_time),
    .win_idx   (w_win),
    .state     (w_state),
    .step_cnt  (w_cnt)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [63:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic pop_chk(input logic [63:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: observed %0d with nothing expected", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_reqs(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] c, input logic [DW-1:0] d);
    dt_req = {d, c, b, a};
  endtask

  initial begin
    rst = 1'b1; rst_w = 1'b1; zero_w = 1'b0; t_stop_w = 8'd0;
    req_w = {4'd10, 4'd10};
    stall_req = 1'b0; stop_en = 1'b0; t_stop = '0;
    set_reqs(16'd50, 16'd20, 16'd20, 16'd90);
    #2;
    push("rst_dt", 0); push("rst_win", 4);
    pop_chk(emu_dt); pop_chk(win_idx);
    step();
    push("rst_time", 0); push("rst_state", 0); push("rst_cnt", 0);
    pop_chk(emu_time); pop_chk(state); pop_chk(step_cnt);

    // min with a tie between requesters 1 and 2
    rst = 1'b0; #1;
    push("min_dt", 20); push("min_win", 1);
    pop_chk(emu_dt); pop_chk(win_idx);
    repeat (3) step();
    push("min_time", 60); push("min_cnt", 3);
    pop_chk(emu_time); pop_chk(step_cnt);

    set_reqs(16'd2000, 16'd2000, 16'd2000, 16'd2000); #1;
    push("cap_dt", 1000); push("cap_win", 4);
    pop_chk(emu_dt); pop_chk(win_idx);
    step();
    push("cap_time", 1060); push("cap_cnt", 4);
    pop_chk(emu_time); pop_chk(step_cnt);

    // reset mid-run, then bring time to 95
    rst = 1'b1; #1;
    push("rst2_dt", 0); push("rst2_win", 4);
    pop_chk(emu_dt); pop_chk(win_idx);
    step();
    push("rst2_time", 0); push("rst2_cnt", 0);
    pop_chk(emu_time); pop_chk(step_cnt);
    rst = 1'b0;
    set_reqs(16'd95, 16'd95, 16'd95, 16'd95); #1;
    push("eq_dt", 95); push("eq_win", 0);
    pop_chk(emu_dt); pop_chk(win_idx);
    step();
    push("t95_time", 95); push("t95_cnt", 1);
    pop_chk(emu_time); pop_chk(step_cnt);

    // stop clamp
    set_reqs(16'd50, 16'd20, 16'd20, 16'd90);
    t_stop = 40'd100; stop_en = 1'b1; #1;
    push("clamp_dt", 5); push("clamp_win", 4); push("clamp_state", 0);
    pop_chk(emu_dt); pop_chk(win_idx); pop_chk(state);
    step();
    push("stop_time", 100); push("stop_state", 2); push("stop_dt", 0); push("stop_cnt", 2);
    pop_chk(emu_time); pop_chk(state); pop_chk(emu_dt); pop_chk(step_cnt);
    step();
    push("stop_hold_state", 2); push("stop_hold_time", 100);
    pop_chk(state); pop_chk(emu_time);
    t_stop = 40'd200; #1;
    push("raise_dt", 0); push("raise_state", 2);
    pop_chk(emu_dt); pop_chk(state);
    step();
    push("resume_state", 0); push("resume_dt", 20); push("resume_win", 1);
    pop_chk(state); pop_chk(emu_dt); pop_chk(win_idx);

    // stall for three cycles
    stall_req = 1'b1; #1;
    push("stall_dt", 0);
    pop_chk(emu_dt);
    for (int i = 0; i < 3; i++) begin
      step();
      push("hold_state", 1); push("hold_time", 100);
      pop_chk(state); pop_chk(emu_time);
    end
    stall_req = 1'b0; #1;
    push("unstall_dt", 0); push("unstall_state", 1);
    pop_chk(emu_dt); pop_chk(state);
    step();
    push("unstall2_state", 0); push("unstall2_dt", 20);
    pop_chk(state); pop_chk(emu_dt);
    step();
    push("unstall_time", 120); push("unstall_cnt", 3);
    pop_chk(emu_time); pop_chk(step_cnt);

    // stall and stop condition together
    t_stop = 40'd130; stall_req = 1'b1; #1;
    push("sv_dt", 0);
    pop_chk(emu_dt);
    step();
    push("sv_state", 1); push("sv_time", 120);
    pop_chk(state); pop_chk(emu_time);
    stall_req = 1'b0; #1;
    push("sv_hold_dt", 0);
    pop_chk(emu_dt);
    step();
    push("sv_run_state", 0); push("sv_clamp_dt", 10); push("sv_clamp_win", 4);
    pop_chk(state); pop_chk(emu_dt); pop_chk(win_idx);
    step();
    push("sv_stop_state", 2); push("sv_stop_time", 130); push("sv_cnt", 4);
    pop_chk(state); pop_chk(emu_time); pop_chk(step_cnt);

    // leave STOP via stop_en, then a zero request
    stop_en = 1'b0; #1;
    push("noen_state", 2); push("noen_dt", 0);
    pop_chk(state); pop_chk(emu_dt);
    step();
    push("noen_run", 0);
    pop_chk(state);
    set_reqs(16'd50, 16'd0, 16'd20, 16'd90); #1;
    push("zero_dt", 0); push("zero_win", 1);
    pop_chk(emu_dt); pop_chk(win_idx);
    step();
    push("zero_cnt", 4); push("zero_time", 130);
    pop_chk(step_cnt); pop_chk(emu_time);

    // reset while granting
    set_reqs(16'd50, 16'd20, 16'd20, 16'd90); #1;
    push("pre_rst_dt", 20);
    pop_chk(emu_dt);
    rst = 1'b1; #1;
    push("rst3_dt", 0); push("rst3_win", 4);
    pop_chk(emu_dt); pop_chk(win_idx);
    step();
    push("rst3_time", 0); push("rst3_state", 0); push("rst3_cnt", 0);
    pop_chk(emu_time); pop_chk(state); pop_chk(step_cnt);
    rst = 1'b0;

    // 8-bit emulated time wraps
    rst_w = 1'b0;
    repeat (25) step();
    push("w_time250", 250); push("w_dt", 10); push("w_state", 0);
    pop_chk(w_time); pop_chk(w_dt); pop_chk(w_state);
    step();
    push("w_wrap", 4); push("w_cnt", 26);
    pop_chk(w_time); pop_chk(w_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
